// File: rtl/progmem_arbiter_if.sv
// progmem_arbiter_if: Avalon-MM style bus bundle with waitrequest and 2-bit response
interface progmem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic [1:0]          response;
  logic                waitrequest;
  modport master (output address, read, write, byteenable, writedata, input readdata, response, waitrequest);
  modport slave (input address, read, write, byteenable, writedata, output readdata, response, waitrequest);
endinterface

// File: rtl/progmem_arbiter.sv
// progmem_arbiter: round-robin two-port arbiter for the program memory wrapper; PROGMEM_ARB_WRITE_PROTECT_EN rejects port-0 writes with SLVERR
module progmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  progmem_arbiter_if.slave  s0,
  progmem_arbiter_if.slave  s1,
  progmem_arbiter_if.master m
);
`ifdef PROGMEM_ARB_WRITE_PROTECT_EN
  typedef enum logic [1:0] {IDLE, BUSY, GAP, ERR} state_t;
  localparam bit WP = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  localparam bit WP = 1'b0;
`endif
  state_t r_state, w_next;
  logic r_grant, r_last_grant, w_next_grant, w_next_last;
  logic w_req0, w_req1, w_pick, w_busy, w_err, w_g_req, w_sel0, w_sel1;
  assign w_req0  = s0.read | s0.write;
  assign w_req1  = s1.read | s1.write;
  assign w_pick  = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
  assign w_busy  = r_state == BUSY;
  assign w_g_req = r_grant ? w_req1 : w_req0;
  assign w_sel0  = w_busy & ~r_grant;
  assign w_sel1  = w_busy & r_grant;
`ifdef PROGMEM_ARB_WRITE_PROTECT_EN
  assign w_err = r_state == ERR;
`else
  assign w_err = 1'b0;
`endif
  // next state, grant and round-robin pointer
  always_comb begin
    w_next       = r_state;
    w_next_grant = r_grant;
    w_next_last  = r_last_grant;
    case (r_state)
      IDLE: if (w_req0 | w_req1) begin
        w_next_grant = w_pick;
        w_next       = BUSY;
`ifdef PROGMEM_ARB_WRITE_PROTECT_EN
        if (!w_pick && s0.write) w_next = ERR;
`endif
      end
      BUSY: if (!w_g_req) w_next = GAP;
        else if (!m.waitrequest) begin
          w_next      = GAP;
          w_next_last = r_grant;
        end
      GAP: w_next = IDLE;
`ifdef PROGMEM_ARB_WRITE_PROTECT_EN
      ERR: begin
        w_next      = IDLE;
        w_next_last = 1'b0;
      end
`endif
      default: w_next = IDLE;
    endcase
  end
  // state register; reset drops any in-flight command on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_next;
      r_grant      <= w_next_grant;
      r_last_grant <= w_next_last;
    end
  end
  assign m.address    = w_busy ? (r_grant ? s1.address : s0.address) : {ADDR_W{1'b0}};
  assign m.read       = w_busy & (r_grant ? s1.read : s0.read);
  assign m.write      = w_busy & (r_grant ? s1.write : s0.write & ~WP);
  assign m.byteenable = w_busy ? (r_grant ? s1.byteenable : s0.byteenable) : {(DATA_W/8){1'b0}};
  assign m.writedata  = w_busy ? (r_grant ? s1.writedata : s0.writedata) : {DATA_W{1'b0}};
  assign s0.waitrequest = w_req0 & ~(w_sel0 & ~m.waitrequest) & ~w_err;
  assign s1.waitrequest = w_req1 & ~(w_sel1 & ~m.waitrequest);
  assign s0.readdata    = w_sel0 ? m.readdata : {DATA_W{1'b0}};
  assign s1.readdata    = w_sel1 ? m.readdata : {DATA_W{1'b0}};
  assign s0.response    = w_err ? 2'b10 : w_sel0 ? m.response : 2'b00;
  assign s1.response    = w_sel1 ? m.response : 2'b00;
endmodule

// File: tb/tb_progmem_arbiter.sv
// tb_progmem_arbiter: directed and randomized checks of progmem_arbiter against a cycle-timeline reference model
module tb_progmem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
`ifdef PROGMEM_ARB_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  progmem_arbiter_if #(AW, DW) s0i();
  progmem_arbiter_if #(AW, DW) s1i();
  progmem_arbiter_if #(AW, DW) mi();
  progmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .s0(s0i), .s1(s1i), .m(mi));

  function automatic logic [31:0] init_word(int a);
    return a == 16 ? 32'hDEADBEEF : a == 32 ? 32'hCAFEF00D : a == 0 ? 32'h0BADF00D : (32'(a) * 32'h01000193) ^ 32'h5A5A5A5A;
  endfunction

  // memory wrapper: two wait cycles, then one completion cycle per command
  logic [31:0] mem [16384];
  logic mem_ready = 1'b0;
  int wcnt = 0;
  logic mem_cmd;
  assign mem_cmd        = mi.read | mi.write;
  assign mi.waitrequest = !(mem_cmd && wcnt == 2);
  assign mi.readdata    = mem[mi.address];
  assign mi.response    = 2'b00;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16384; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mi.write && wcnt == 2)
      for (int b = 0; b < 4; b++) if (mi.byteenable[b]) mem[mi.address][8*b +: 8] <= mi.writedata[8*b +: 8];
    wcnt <= (!rst_n || !mem_cmd) ? 0 : wcnt + 1;
  end

  logic rd[2], wr[2], seen[2];
  logic [13:0] ad[2];
  logic [31:0] wd[2];
  logic [3:0] be[2];
  logic rst_v;
  bit rand_en, renew, chk_en;
  int cyc, n_tests, n_fail, t0;
  logic [31:0] ref_mem [16384];
  bit md_active, md_err, md_last, md_cur;
  int md_gnt, md_done, md_eval;
  int obs[$];
  int obs_cyc[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    rst_n = rst_v;
    s0i.read = rd[0]; s0i.write = wr[0]; s0i.address = ad[0]; s0i.writedata = wd[0]; s0i.byteenable = be[0];
    s1i.read = rd[1]; s1i.write = wr[1]; s1i.address = ad[1]; s1i.writedata = wd[1]; s1i.byteenable = be[1];
  endtask

  // timeline model: grant decided in an idle cycle, completion 3 cycles later (1 for a rejected write), idle again 2 cycles after
  task automatic model();
    logic req[2], wq[2];
    logic [31:0] got_rd;
    logic [1:0] got_rs;
    bit fin, exp_cmd;
    req[0] = rd[0] | wr[0];
    req[1] = rd[1] | wr[1];
    wq[0] = s0i.waitrequest;
    wq[1] = s1i.waitrequest;
    if (rst_v && !md_active && cyc >= md_eval && (req[0] || req[1])) begin
      md_cur    = (req[0] && req[1]) ? !md_last : req[1];
      md_err    = WP && !md_cur && wr[0];
      md_gnt    = cyc;
      md_done   = cyc + (md_err ? 1 : 3);
      md_active = 1'b1;
    end
    fin = md_active && cyc == md_done;
    if (chk_en) begin
      check("s0_waitrequest", wq[0], req[0] && !(fin && !md_cur));
      check("s1_waitrequest", wq[1], req[1] && !(fin && md_cur));
      exp_cmd = md_active && !md_err && cyc > md_gnt;
      check("m_read", mi.read, exp_cmd && rd[md_cur]);
      check("m_write", mi.write, exp_cmd && wr[md_cur]);
      if (exp_cmd) check("m_address", mi.address, ad[md_cur]);
      if (fin) begin
        got_rd = md_cur ? s1i.readdata : s0i.readdata;
        got_rs = md_cur ? s1i.response : s0i.response;
        if (md_err) check("s0_err_response", s0i.response, 32'h2);
        else begin
          check("response", got_rs, 0);
          if (rd[md_cur]) check("readdata", got_rd, ref_mem[ad[md_cur]]);
        end
      end
    end
    if (fin) begin
      if (!md_err && wr[md_cur])
        for (int b = 0; b < 4; b++) if (be[md_cur][b]) ref_mem[ad[md_cur]][8*b +: 8] = wd[md_cur][8*b +: 8];
      md_last   = md_err ? 1'b0 : md_cur;
      md_active = 1'b0;
      md_eval   = cyc + (md_err ? 1 : 2);
    end
    for (int p = 0; p < 2; p++) begin
      seen[p] = req[p] && !wq[p];
      if (seen[p]) begin
        obs.push_back(p);
        obs_cyc.push_back(cyc);
      end
    end
    if (!rst_v) begin
      md_active = 1'b0;
      md_last   = 1'b1;
      md_eval   = cyc + 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int p = 0; p < 2; p++) begin
      if (seen[p] && !renew) begin
        rd[p] = 1'b0;
        wr[p] = 1'b0;
      end
      seen[p] = 1'b0;
      if (rand_en && !rd[p] && !wr[p] && $urandom_range(0, 2) == 0) begin
        rd[p] = 1'($urandom_range(0, 1));
        wr[p] = !rd[p];
        ad[p] = 14'($urandom_range(0, 15));
        wd[p] = $urandom;
        be[p] = 4'($urandom_range(1, 15));
      end
    end
    drive();
    #3;
    model();
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((rd[0] || wr[0] || rd[1] || wr[1] || md_active) && n < 60) begin
      step();
      n++;
    end
    check("quiet_in_time", n < 60, 1);
    step();
    step();
  endtask

  initial begin
    int exp_ord[4] = '{0, 1, 0, 1};
    int exp_off[4] = '{3, 8, 13, 18};
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      rd[p] = 1'b0; wr[p] = 1'b0; seen[p] = 1'b0; ad[p] = '0; wd[p] = '0; be[p] = '0;
    end
    rst_v = 1'b0;
    md_last = 1'b1;
    drive();
    step();
    step();
    rst_v = 1'b1;
    chk_en = 1'b1;
    step();
    check("rst_m_read", mi.read, 0);
    check("rst_m_write", mi.write, 0);
    check("rst_m_address", mi.address, 0);
    check("rst_m_writedata", mi.writedata, 0);
    check("rst_s0_readdata", s0i.readdata, 0);
    check("rst_s1_response", s1i.response, 0);
    // single read of a known word
    rd[0] = 1'b1; ad[0] = 14'h0010;
    step();
    check("t1_c0_s0_wait", s0i.waitrequest, 1);
    step();
    check("t1_c1_m_read", mi.read, 1);
    step();
    step();
    check("t1_c3_s0_wait", s0i.waitrequest, 0);
    check("t1_c3_readdata", s0i.readdata, 32'hDEADBEEF);
    check("t1_c3_resp", s0i.response, 0);
    step();
    check("t1_c4_m_read", mi.read, 0);
    wait_quiet();
    // both ports request continuously from reset
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    obs.delete();
    obs_cyc.delete();
    renew = 1'b1;
    rd[0] = 1'b1; ad[0] = 14'h0001; rd[1] = 1'b1; ad[1] = 14'h0002;
    step();
    t0 = cyc;
    repeat (18) step();
    renew = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_order", i < obs.size() ? obs[i] : 9, exp_ord[i]);
      check("t2_when", i < obs.size() ? obs_cyc[i] - t0 : -1, exp_off[i]);
    end
    wait_quiet();
    // partial write on s1 then read back on s0
    wr[1] = 1'b1; ad[1] = 14'h0020; wd[1] = 32'h12345678; be[1] = 4'b0011;
    step();
    rd[0] = 1'b1; ad[0] = 14'h0020;
    step();
    step();
    step();
    check("t3_c3_s1_wait", s1i.waitrequest, 0);
    step();
    check("t3_gap_m_read", mi.read, 0);
    check("t3_gap_m_write", mi.write, 0);
    check("t3_gap_s0_wait", s0i.waitrequest, 1);
    repeat (4) step();
    check("t3_c8_s0_wait", s0i.waitrequest, 0);
    check("t3_merged", s0i.readdata, 32'hCAFE5678);
    wait_quiet();
    // reset pulse while busy
    rd[0] = 1'b1; ad[0] = 14'h0005;
    step();
    step();
    rst_v = 1'b0;
    step();
    check("t4_c2_s0_wait", s0i.waitrequest, 1);
    rst_v = 1'b1;
    step();
    check("t4_c3_m_read", mi.read, 0);
    check("t4_c3_s0_wait", s0i.waitrequest, 1);
    repeat (3) step();
    check("t4_c6_s0_wait", s0i.waitrequest, 0);
    wait_quiet();
`ifdef PROGMEM_ARB_WRITE_PROTECT_EN
    // port-0 write is rejected and memory left intact
    wr[0] = 1'b1; ad[0] = 14'h0000; wd[0] = 32'hFFFFFFFF; be[0] = 4'hF;
    step();
    step();
    check("t5_err_wait", s0i.waitrequest, 0);
    check("t5_err_resp", s0i.response, 32'h2);
    check("t5_err_m_write", mi.write, 0);
    wait_quiet();
    rd[0] = 1'b1; ad[0] = 14'h0000;
    repeat (4) step();
    check("t5_read_wait", s0i.waitrequest, 0);
    check("t5_read_orig", s0i.readdata, 32'h0BADF00D);
    wait_quiet();
`endif
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    wait_quiet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
